// File: rtl/led_strip_sequencer.sv
// Frame sequencer for a serial LED driver: holds a pixel buffer and streams it
// pixel by pixel over a valid/ready handshake, then idles for the latch gap.
module led_strip_sequencer #(
  parameter  int NUM_LEDS     = 16,
  parameter  int LATCH_CYCLES = 30000,
  localparam int AW           = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          wr_en_in,
  input  logic [AW-1:0] wr_addr_in,
  input  logic [23:0]   wr_data_in,
  input  logic          start_in,
  input  logic          ready_in,
  output logic [23:0]   rgb_out,
  output logic          valid_out,
  output logic          busy_out,
  output logic          done_out
);

  localparam int DEPTH = 1 << AW;
  localparam int CW    = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES + 1) : 1;

  localparam logic [AW-1:0] LAST_IDX     = AW'(NUM_LEDS - 1);
  localparam logic [AW:0]   NUM_LEDS_EXT = (AW + 1)'(NUM_LEDS);
  localparam logic [CW-1:0] LATCH_LAST   = CW'(LATCH_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SEND,
    DRAIN,
    LATCH
  } state_t;

  state_t        state;
  logic [AW-1:0] index;
  logic [CW-1:0] latch_cnt;
  logic          drain_armed;
  logic          wr_ok;

  logic [23:0]   pixel_mem [DEPTH];

  assign wr_ok = wr_en_in && ({1'b0, wr_addr_in} < NUM_LEDS_EXT);

  // Buffer is never reset; a same-cycle read in FETCH sees the old word.
  always_ff @(posedge clk_in) begin
    if (wr_ok) begin
      pixel_mem[wr_addr_in] <= wr_data_in;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state       <= IDLE;
      index       <= '0;
      latch_cnt   <= '0;
      drain_armed <= 1'b0;
      rgb_out     <= '0;
      valid_out   <= 1'b0;
      busy_out    <= 1'b0;
      done_out    <= 1'b0;
    end else begin
      done_out <= 1'b0;
      case (state)
        IDLE: begin
          // A start coinciding with the done pulse is dropped.
          if (start_in && !done_out) begin
            state    <= FETCH;
            index    <= '0;
            busy_out <= 1'b1;
          end
        end
        FETCH: begin
          rgb_out   <= pixel_mem[index];
          valid_out <= 1'b1;
          state     <= SEND;
        end
        SEND: begin
          if (ready_in) begin
            valid_out <= 1'b0;
            if (index != LAST_IDX) begin
              index <= index + 1'b1;
              state <= FETCH;
            end else begin
              drain_armed <= 1'b0;
              state       <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Skip one cycle so a registered ready from the driver has time to drop.
          if (!drain_armed) begin
            drain_armed <= 1'b1;
          end else if (ready_in) begin
            latch_cnt <= '0;
            state     <= LATCH;
          end
        end
        LATCH: begin
          if (latch_cnt == LATCH_LAST) begin
            latch_cnt <= '0;
            busy_out  <= 1'b0;
            done_out  <= 1'b1;
            state     <= IDLE;
          end else begin
            latch_cnt <= latch_cnt + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          valid_out <= 1'b0;
          busy_out  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_strip_sequencer.sv
// Directed bench for led_strip_sequencer: a vector table for the first frame,
// then hand-written sequences for stall, start filtering, read-first and reset.
module tb_led_strip_sequencer;

  localparam int N   = 5;
  localparam int LAT = 100;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [23:0] wr_data;
  logic        start;
  logic        ready;
  logic [23:0] rgb;
  logic        valid;
  logic        busy;
  logic        done;

  int tests;
  int fails;

  typedef struct {
    logic        wr_en;
    logic [2:0]  addr;
    logic [23:0] data;
    logic        start;
    logic        ready;
    logic        e_valid;
    logic [23:0] e_rgb;
    logic        e_busy;
    logic        e_done;
  } vec_t;

  vec_t        vecs [21];
  logic [23:0] px [N];

  led_strip_sequencer #(
    .NUM_LEDS    (N),
    .LATCH_CYCLES(LAT)
  ) dut (
    .clk_in    (clk),
    .rst_in    (rst_n),
    .wr_en_in  (wr_en),
    .wr_addr_in(wr_addr),
    .wr_data_in(wr_data),
    .start_in  (start),
    .ready_in  (ready),
    .rgb_out   (rgb),
    .valid_out (valid),
    .busy_out  (busy),
    .done_out  (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input int we, input int a, input logic [23:0] d,
                              input int st, input int rd, input int ev,
                              input logic [23:0] er, input int eb, input int ed);
    vec_t v;
    v.wr_en   = 1'(we);
    v.addr    = 3'(a);
    v.data    = d;
    v.start   = 1'(st);
    v.ready   = 1'(rd);
    v.e_valid = 1'(ev);
    v.e_rgb   = er;
    v.e_busy  = 1'(eb);
    v.e_done  = 1'(ed);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int bad;
    int n;
    tests   = 0;
    fails   = 0;
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    start   = 1'b0;
    ready   = 1'b0;

    px[0] = 24'hFF00FF; px[1] = 24'h00FF00; px[2] = 24'h123456;
    px[3] = 24'hABCDEF; px[4] = 24'h0F0F0F;

    vecs[0]  = mk(1, 0, 24'hFF00FF, 0, 0, 0, 24'h0, 0, 0);
    vecs[1]  = mk(1, 1, 24'h00FF00, 0, 0, 0, 24'h0, 0, 0);
    vecs[2]  = mk(1, 2, 24'h123456, 0, 0, 0, 24'h0, 0, 0);
    vecs[3]  = mk(1, 3, 24'hABCDEF, 0, 0, 0, 24'h0, 0, 0);
    vecs[4]  = mk(1, 4, 24'h0F0F0F, 0, 0, 0, 24'h0, 0, 0);
    vecs[5]  = mk(1, 5, 24'hDEAD01, 0, 0, 0, 24'h0, 0, 0);
    vecs[6]  = mk(0, 0, 24'h0,      1, 1, 0, 24'h0, 1, 0);
    vecs[7]  = mk(0, 0, 24'h0,      0, 1, 1, 24'hFF00FF, 1, 0);
    vecs[8]  = mk(0, 0, 24'h0,      0, 1, 0, 24'h0, 1, 0);
    vecs[9]  = mk(0, 0, 24'h0,      0, 0, 1, 24'h00FF00, 1, 0);
    vecs[10] = mk(0, 0, 24'h0,      0, 0, 1, 24'h00FF00, 1, 0);
    vecs[11] = mk(0, 0, 24'h0,      0, 1, 0, 24'h0, 1, 0);
    vecs[12] = mk(0, 0, 24'h0,      0, 1, 1, 24'h123456, 1, 0);
    vecs[13] = mk(0, 0, 24'h0,      0, 1, 0, 24'h0, 1, 0);
    vecs[14] = mk(0, 0, 24'h0,      0, 1, 1, 24'hABCDEF, 1, 0);
    vecs[15] = mk(0, 0, 24'h0,      0, 1, 0, 24'h0, 1, 0);
    vecs[16] = mk(0, 0, 24'h0,      0, 1, 1, 24'h0F0F0F, 1, 0);
    vecs[17] = mk(0, 0, 24'h0,      0, 1, 0, 24'h0, 1, 0);
    vecs[18] = mk(0, 0, 24'h0,      0, 0, 0, 24'h0, 1, 0);
    vecs[19] = mk(0, 0, 24'h0,      0, 0, 0, 24'h0, 1, 0);
    vecs[20] = mk(0, 0, 24'h0,      0, 1, 0, 24'h0, 1, 0);

    // Reset state
    #12;
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_busy",  32'(busy),  32'd0);
    chk("reset_done",  32'(done),  32'd0);
    chk("reset_rgb",   32'(rgb),   32'd0);
    tick();
    rst_n = 1'b1;

    // First frame from the vector table
    for (int i = 0; i < 21; i++) begin
      wr_en   = vecs[i].wr_en;
      wr_addr = vecs[i].addr;
      wr_data = vecs[i].data;
      start   = vecs[i].start;
      ready   = vecs[i].ready;
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(valid), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d_busy", i),  32'(busy),  32'(vecs[i].e_busy));
      chk($sformatf("vec%0d_done", i),  32'(done),  32'(vecs[i].e_done));
      if (vecs[i].e_valid)
        chk($sformatf("vec%0d_rgb", i), 32'(rgb), 32'(vecs[i].e_rgb));
    end
    wr_en = 1'b0;

    // Latch gap: 100 quiet cycles in total, then one done pulse
    bad = 0;
    for (int i = 1; i < LAT; i++) begin
      tick();
      if (valid || done || !busy) bad++;
    end
    chk("latch_quiet", 32'(bad), 32'd0);
    tick();
    chk("latch_done",      32'(done),  32'd1);
    chk("latch_busy_fall", 32'(busy),  32'd0);
    chk("latch_valid",     32'(valid), 32'd0);
    tick();
    chk("done_one_cycle", 32'(done), 32'd0);

    // Second frame: write during FETCH (read-first), long stall, stray starts
    ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("f2_fetch_busy",  32'(busy),  32'd1);
    chk("f2_fetch_valid", 32'(valid), 32'd0);
    wr_en   = 1'b1;
    wr_addr = 3'd0;
    wr_data = 24'h111111;
    tick();
    wr_en = 1'b0;
    chk("read_first_valid", 32'(valid), 32'd1);
    chk("read_first_rgb",   32'(rgb),   32'hFF00FF);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      start = (i == 10);
      tick();
      if (!valid || rgb !== 24'hFF00FF) bad++;
    end
    start = 1'b0;
    chk("stall_stable", 32'(bad), 32'd0);
    ready = 1'b1;
    tick();
    chk("stall_single_xfer", 32'(valid), 32'd0);
    for (int p = 1; p < N; p++) begin
      tick();
      chk($sformatf("f2_px%0d_valid", p), 32'(valid), 32'd1);
      chk($sformatf("f2_px%0d_rgb", p),   32'(rgb),   32'(px[p]));
      tick();
      chk($sformatf("f2_px%0d_gap", p),   32'(valid), 32'd0);
    end
    n   = 0;
    bad = 0;
    while (!done && n < 200) begin
      tick();
      n++;
      if (valid) bad++;
    end
    chk("f2_done_latency", 32'(n),    32'd102);
    chk("f2_latch_valid",  32'(bad),  32'd0);
    chk("f2_done_busy",    32'(busy), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_on_done_ignored", 32'(busy), 32'd0);
    tick();
    chk("no_extra_frame_busy",  32'(busy),  32'd0);
    chk("no_extra_frame_valid", 32'(valid), 32'd0);

    // Third frame picks up the new word; async reset mid-SEND
    start = 1'b1;
    tick();
    start = 1'b0;
    ready = 1'b0;
    tick();
    chk("new_value_valid", 32'(valid), 32'd1);
    chk("new_value_rgb",   32'(rgb),   32'h111111);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(valid), 32'd0);
    chk("async_rst_busy",  32'(busy),  32'd0);
    chk("async_rst_done",  32'(done),  32'd0);
    chk("async_rst_rgb",   32'(rgb),   32'd0);
    tick();
    rst_n = 1'b1;
    ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 130; i++) begin
      tick();
      if (done || busy || valid) bad++;
    end
    chk("abandoned_frame_quiet", 32'(bad), 32'd0);

    // After reset a new frame starts again from pixel 0
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("restart_px0_valid", 32'(valid), 32'd1);
    chk("restart_px0_rgb",   32'(rgb),   32'h111111);
    tick();
    chk("restart_gap", 32'(valid), 32'd0);
    tick();
    chk("restart_px1_rgb", 32'(rgb), 32'h00FF00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
